// File: rtl/coef_bank_loader.sv
// Streams FIR coefficients into a shadow bank and commits complete frames to the active bank in one edge.
// Build option COEF_SYMMETRIC_EN: half-length linear-phase frames, each beat mirrored into both halves.
module coef_bank_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int Q_FORMAT   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_WIDTH-1:0]  coefIn,
  input  logic                          coefValid,
  input  logic                          coefLast,
  output logic                          coefReady,
  output logic signed [DATA_WIDTH-1:0]  coefs [0:NUM_REGS-1],
  output logic                          bankSwapped,
  output logic                          loadError,
  output logic                          busy,
  output logic [$clog2(NUM_REGS+1)-1:0] loadCount
);

  localparam int CNT_W = $clog2(NUM_REGS + 1);
`ifdef COEF_SYMMETRIC_EN
  localparam int EXP = (NUM_REGS + 1) / 2;
`else
  localparam int EXP = NUM_REGS;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(EXP - 1);

  // Q_FORMAT only documents the number format; reject nonsensical values at elaboration.
  if (Q_FORMAT < 0 || Q_FORMAT >= DATA_WIDTH) begin : g_bad_q_format
    $error("coef_bank_loader: Q_FORMAT must lie in [0, DATA_WIDTH)");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SWAP = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic signed [DATA_WIDTH-1:0]  shadow_q [0:NUM_REGS-1];
  logic signed [DATA_WIDTH-1:0]  shadow_d [0:NUM_REGS-1];
  logic signed [DATA_WIDTH-1:0]  bank_q   [0:NUM_REGS-1];
  logic signed [DATA_WIDTH-1:0]  bank_d   [0:NUM_REGS-1];
  logic                          swapped_q, swapped_d;
  logic                          error_q, error_d;
  logic                          xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      swapped_q <= 1'b0;
      error_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        bank_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      swapped_q <= swapped_d;
      error_q   <= error_d;
      shadow_q  <= shadow_d;
      bank_q    <= bank_d;
    end
  end

  assign xfer = coefValid && coefReady;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    shadow_d  = shadow_q;
    bank_d    = bank_q;
    swapped_d = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (xfer) begin
          for (int i = 0; i < NUM_REGS; i++) begin
`ifdef COEF_SYMMETRIC_EN
            if (CNT_W'(i) == count_q || CNT_W'(NUM_REGS - 1 - i) == count_q) begin
              shadow_d[i] = coefIn;
            end
`else
            if (CNT_W'(i) == count_q) begin
              shadow_d[i] = coefIn;
            end
`endif
          end
          if (count_q == LAST_IDX) begin
            count_d = '0;
            if (coefLast) begin
              state_d = ST_SWAP;
            end else begin
              error_d = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (coefLast) begin
            count_d = '0;
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            count_d = count_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_SWAP: begin
        bank_d    = shadow_q;
        swapped_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    coefReady   = (state_q != ST_SWAP);
    busy        = (state_q != ST_IDLE);
    bankSwapped = swapped_q;
    loadError   = error_q;
    loadCount   = count_q;
    coefs       = bank_q;
  end

endmodule

// File: tb/tb_coef_bank_loader.sv
// Self-checking bench for coef_bank_loader: directed scenarios plus a randomized run against a frame-level model.
// Honours COEF_SYMMETRIC_EN (runs with NUM_REGS=7 and mirrored frames when defined).
module tb_coef_bank_loader;

`ifdef COEF_SYMMETRIC_EN
  localparam int NUM_REGS = 7;
  localparam int EXP = (NUM_REGS + 1) / 2;
`else
  localparam int NUM_REGS = 8;
  localparam int EXP = NUM_REGS;
`endif
  localparam int DW = 16;
  localparam int CW = $clog2(NUM_REGS + 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] coef_in;
  logic                 coef_valid;
  logic                 coef_last;
  logic                 coef_ready;
  logic signed [DW-1:0] coefs [0:NUM_REGS-1];
  logic                 bank_swapped;
  logic                 load_error;
  logic                 busy;
  logic [CW-1:0]        load_count;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_bank [0:NUM_REGS-1];
  logic [DW-1:0] frame_q [$];

  coef_bank_loader #(.DATA_WIDTH(DW), .NUM_REGS(NUM_REGS), .Q_FORMAT(8)) dut (
    .clk(clk), .rst(rst), .coefIn(coef_in), .coefValid(coef_valid), .coefLast(coef_last),
    .coefReady(coef_ready), .coefs(coefs), .bankSwapped(bank_swapped), .loadError(load_error),
    .busy(busy), .loadCount(load_count)
  );

  always #5 clk = ~clk;

  // Active bank implied by a complete frame: tap j takes beat j (mirrored beat when symmetric).
  function automatic void expand_frame();
    for (int j = 0; j < NUM_REGS; j++) begin
`ifdef COEF_SYMMETRIC_EN
      exp_bank[j] = frame_q[(j < NUM_REGS - 1 - j) ? j : NUM_REGS - 1 - j];
`else
      exp_bank[j] = frame_q[j];
`endif
    end
  endfunction

  function automatic int first_diff();
    for (int j = 0; j < NUM_REGS; j++) if (coefs[j] !== exp_bank[j]) return j;
    return -1;
  endfunction

  task automatic step(input logic v, input logic [DW-1:0] d, input logic l);
    coef_valid = v;
    coef_in    = d;
    coef_last  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bool_last_on_final);
    for (int i = 0; i < frame_q.size(); i++)
      step(1'b1, frame_q[i], bool_last_on_final && (i == frame_q.size() - 1));
  endtask

  task automatic test_reset();
    int d;
    rst = 1'b1; coef_valid = 1'b0; coef_in = '0; coef_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 0; j < NUM_REGS; j++) exp_bank[j] = '0;
    total++; if (coef_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", coef_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (load_count !== '0) begin bad++; $display("FAIL reset_count got %0d want 0", load_count); end
    total++; if (bank_swapped !== 1'b0 || load_error !== 1'b0) begin
      bad++; $display("FAIL reset_pulses got swap=%b err=%b want 0 0", bank_swapped, load_error); end
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL reset_coefs tap %0d got %h want %h", d, coefs[d], exp_bank[d]); end
  endtask

  task automatic test_basic_load();
    int d;
    frame_q.delete();
    for (int i = 0; i < EXP; i++) frame_q.push_back(DW'(i + 1));
    for (int i = 0; i < EXP; i++) begin
      step(1'b1, frame_q[i], i == EXP - 1);
      if (i < EXP - 1) begin
        total++; if (load_count !== CW'(i + 1)) begin bad++; $display("FAIL basic_count got %0d want %0d", load_count, i + 1); end
      end
    end
    total++; if (coef_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_swap_state got ready=%b busy=%b want 0 1", coef_ready, busy); end
    total++; if (bank_swapped !== 1'b0) begin bad++; $display("FAIL basic_early_swap got %b want 0", bank_swapped); end
    step(1'b0, '0, 1'b0);
    expand_frame();
    total++; if (bank_swapped !== 1'b1) begin bad++; $display("FAIL basic_swapped got %b want 1", bank_swapped); end
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL basic_coefs tap %0d got %h want %h", d, coefs[d], exp_bank[d]); end
    total++; if (busy !== 1'b0 || coef_ready !== 1'b1) begin
      bad++; $display("FAIL basic_idle got busy=%b ready=%b want 0 1", busy, coef_ready); end
    step(1'b0, '0, 1'b0);
    total++; if (bank_swapped !== 1'b0) begin bad++; $display("FAIL basic_pulse_width got %b want 0", bank_swapped); end
  endtask

  task automatic test_short_frame();
    int d;
    int short_len = (EXP > 3) ? EXP - 3 : 1;
    frame_q.delete();
    for (int i = 0; i < short_len; i++) frame_q.push_back(16'h0100);
    send_frame(1'b1);
    total++; if (load_error !== 1'b1) begin bad++; $display("FAIL short_error got %b want 1", load_error); end
    total++; if (bank_swapped !== 1'b0 || busy !== 1'b0 || load_count !== '0) begin
      bad++; $display("FAIL short_flags got swap=%b busy=%b cnt=%0d want 0 0 0", bank_swapped, busy, load_count); end
    step(1'b0, '0, 1'b0);
    total++; if (load_error !== 1'b0 || bank_swapped !== 1'b0) begin
      bad++; $display("FAIL short_pulse got err=%b swap=%b want 0 0", load_error, bank_swapped); end
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL short_bank_kept tap %0d got %h want %h", d, coefs[d], exp_bank[d]); end
    frame_q.delete();
    for (int i = 0; i < EXP; i++) frame_q.push_back(16'h0040);
    send_frame(1'b1);
    step(1'b0, '0, 1'b0);
    expand_frame();
    d = first_diff();
    total++; if (bank_swapped !== 1'b1 || d >= 0) begin
      bad++; $display("FAIL short_reload got swap=%b diff_tap=%0d want 1 -1", bank_swapped, d); end
  endtask

  task automatic test_overrun();
    int d;
    for (int i = 0; i < EXP; i++) step(1'b1, 16'h7FFF, 1'b0);
    total++; if (load_error !== 1'b1 || load_count !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL overrun_error got err=%b cnt=%0d busy=%b want 1 0 0", load_error, load_count, busy); end
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL overrun_bank_kept tap %0d got %h want %h", d, coefs[d], exp_bank[d]); end
    frame_q.delete();
    for (int i = 0; i < EXP; i++) frame_q.push_back(DW'(16'h1000 + i));
    step(1'b1, frame_q[0], EXP == 1);
    if (EXP > 1) begin
      total++; if (load_count !== CW'(1) || load_error !== 1'b0) begin
        bad++; $display("FAIL overrun_restart got cnt=%0d err=%b want 1 0", load_count, load_error); end
    end
    for (int i = 1; i < EXP; i++) step(1'b1, frame_q[i], i == EXP - 1);
    step(1'b0, '0, 1'b0);
    expand_frame();
    d = first_diff();
    total++; if (bank_swapped !== 1'b1 || d >= 0) begin
      bad++; $display("FAIL overrun_reload got swap=%b diff_tap=%0d want 1 -1", bank_swapped, d); end
  endtask

  task automatic test_stall();
    int d;
    frame_q.delete();
    for (int i = 0; i < EXP; i++) frame_q.push_back(DW'(16'h8000 + i));
    for (int i = 0; i < EXP; i++) begin
      step(1'b1, frame_q[i], i == EXP - 1);
      if (i < EXP - 1) begin
        // Gap cycle drives junk with coefLast high: nothing may be sampled.
        step(1'b0, 16'hDEAD, 1'b1);
        total++; if (load_count !== CW'(i + 1) || busy !== 1'b1 || load_error !== 1'b0) begin
          bad++; $display("FAIL stall_hold got cnt=%0d busy=%b err=%b want %0d 1 0", load_count, busy, load_error, i + 1); end
      end
    end
    step(1'b0, '0, 1'b0);
    expand_frame();
    d = first_diff();
    total++; if (bank_swapped !== 1'b1 || d >= 0) begin
      bad++; $display("FAIL stall_coefs got swap=%b diff_tap=%0d want 1 -1", bank_swapped, d); end
  endtask

  task automatic test_reset_mid_frame();
    int d;
    int mid = (EXP > 4) ? 4 : EXP - 1;
    for (int i = 0; i < mid; i++) step(1'b1, DW'(16'h0300 + i), 1'b0);
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    for (int j = 0; j < NUM_REGS; j++) exp_bank[j] = '0;
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL rstmid_coefs tap %0d got %h want %h", d, coefs[d], exp_bank[d]); end
    total++; if (load_count !== '0 || busy !== 1'b0 || bank_swapped !== 1'b0 || load_error !== 1'b0) begin
      bad++; $display("FAIL rstmid_flags got cnt=%0d busy=%b swap=%b err=%b want 0 0 0 0",
                      load_count, busy, bank_swapped, load_error); end
    rst = 1'b0;
    // Complete a frame, then reset while the swap is pending.
    frame_q.delete();
    for (int i = 0; i < EXP; i++) frame_q.push_back(DW'(16'h0500 + i));
    send_frame(1'b1);
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
    step(1'b0, '0, 1'b0);
    d = first_diff();
    total++; if (bank_swapped !== 1'b0 || d >= 0) begin
      bad++; $display("FAIL rstswap_lost got swap=%b diff_tap=%0d want 0 -1", bank_swapped, d); end
    frame_q.delete();
    for (int i = 0; i < EXP; i++) frame_q.push_back(DW'(16'h0200 + 3 * i));
    send_frame(1'b1);
    step(1'b0, '0, 1'b0);
    expand_frame();
    d = first_diff();
    total++; if (bank_swapped !== 1'b1 || d >= 0) begin
      bad++; $display("FAIL rstmid_reload got swap=%b diff_tap=%0d want 1 -1", bank_swapped, d); end
  endtask

`ifdef COEF_SYMMETRIC_EN
  task automatic test_symmetric();
    int d;
    logic [DW-1:0] want [0:6];
    want[0] = 16'd10; want[1] = 16'd20; want[2] = 16'd30; want[3] = 16'd40;
    want[4] = 16'd30; want[5] = 16'd20; want[6] = 16'd10;
    step(1'b1, 16'd10, 1'b0);
    step(1'b1, 16'd20, 1'b0);
    step(1'b1, 16'd30, 1'b0);
    step(1'b1, 16'd40, 1'b1);
    step(1'b0, '0, 1'b0);
    for (int j = 0; j < NUM_REGS; j++) exp_bank[j] = want[j];
    d = first_diff();
    total++; if (bank_swapped !== 1'b1 || d >= 0) begin
      bad++; $display("FAIL sym_coefs got swap=%b diff_tap=%0d want 1 -1", bank_swapped, d); end
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0);
    total++; if (load_error !== 1'b1) begin bad++; $display("FAIL sym_overrun got %b want 1", load_error); end
    step(1'b1, 16'd5, 1'b1);
    total++; if (load_error !== 1'b1) begin bad++; $display("FAIL sym_fifth_short got %b want 1", load_error); end
    step(1'b0, '0, 1'b0);
    d = first_diff();
    total++; if (bank_swapped !== 1'b0 || d >= 0) begin
      bad++; $display("FAIL sym_bank_kept got swap=%b diff_tap=%0d want 0 -1", bank_swapped, d); end
  endtask
`endif

  task automatic test_random();
    bit pend;
    bit sw, er, v, l, do_rst;
    logic [DW-1:0] dat;
    int d;
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
    for (int j = 0; j < NUM_REGS; j++) exp_bank[j] = '0;
    frame_q.delete();
    pend = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      total++; if (coef_ready !== !pend) begin bad++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, coef_ready, !pend); end
      v   = ($urandom_range(0, 3) != 0);
      dat = DW'($urandom_range(0, 65535));
      l   = (frame_q.size() + 1 == EXP) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 11) == 0);
      do_rst = ($urandom_range(0, 199) == 0);
      rst = do_rst;
      step(v, dat, l);
      rst = 1'b0;
      sw = 1'b0; er = 1'b0;
      if (do_rst) begin
        for (int j = 0; j < NUM_REGS; j++) exp_bank[j] = '0;
        frame_q.delete();
        pend = 1'b0;
      end else if (pend) begin
        expand_frame();
        frame_q.delete();
        pend = 1'b0;
        sw = 1'b1;
      end else if (v) begin
        frame_q.push_back(dat);
        if (l && frame_q.size() == EXP) pend = 1'b1;
        else if (l || frame_q.size() == EXP) begin er = 1'b1; frame_q.delete(); end
      end
      total++; if (bank_swapped !== sw || load_error !== er) begin
        bad++; $display("FAIL rnd_pulses cyc %0d got swap=%b err=%b want %b %b", cyc, bank_swapped, load_error, sw, er); end
      total++; if (load_count !== CW'(pend ? 0 : frame_q.size()) || busy !== (pend || frame_q.size() > 0)) begin
        bad++; $display("FAIL rnd_count cyc %0d got cnt=%0d busy=%b want %0d %b", cyc, load_count, busy,
                        pend ? 0 : frame_q.size(), pend || frame_q.size() > 0); end
      d = first_diff();
      total++; if (d >= 0) begin bad++; $display("FAIL rnd_coefs cyc %0d tap %0d got %h want %h", cyc, d, coefs[d], exp_bank[d]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_short_frame();
    test_overrun();
    test_stall();
    test_reset_mid_frame();
`ifdef COEF_SYMMETRIC_EN
    test_symmetric();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coef_bank_loader.md
Name: coef_bank_loader

Overview:
- Sequential writer for the FIR tap-coefficient array that the multiply-accumulate unit reads combinationally.
- Accepts a valid/ready coefficient stream into a shadow bank.
- Checks the frame length against coefLast.
- Commits the frame atomically to the active bank driving coefs, so the MAC never sees a partially loaded filter.

Parameters:
DATA_WIDTH, 16, coefficient width, signed Q(DATA_WIDTH-Q_FORMAT).Q_FORMAT; matches constants.svh
NUM_REGS, 8, number of taps / coefficients; matches constants.svh
Q_FORMAT, 8, fractional bits; informational only, no arithmetic depends on it

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
coefIn  input  DATA_WIDTH signed  coefficient beat
coefValid  input  1  coefIn valid
coefLast  input  1  marks final beat of a frame; qualified by coefValid
coefReady  output  1  loader accepts a beat this cycle
coefs  output  DATA_WIDTH signed x [0:NUM_REGS-1]  active bank to MAC
bankSwapped  output  1  one-cycle pulse: coefs updated
loadError  output  1  one-cycle pulse: frame length error, frame discarded
busy  output  1  frame in progress or swap pending
loadCount  output  $clog2(NUM_REGS+1)  beats accepted in current frame

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state=IDLE, all coefs=0, all shadow entries=0, loadCount=0.
  - bankSwapped=0, loadError=0, busy=0.
  - coefReady=1 in the first cycle after reset deasserts.
- Handshake:
  - A beat transfers on any rising edge with coefValid && coefReady.
  - coefIn and coefLast are sampled only on a transfer.
  - coefReady is combinational from state: 1 in IDLE and LOAD, 0 in SWAP.
- Expected frame length: EXP = NUM_REGS (see Optional Feature).
- On each transfer:
  - shadow[loadCount] <= coefIn.
  - If coefLast && loadCount==EXP-1: go to SWAP, loadCount <= 0.
  - Else if coefLast && loadCount<EXP-1 (short frame): loadError pulses next cycle, loadCount <= 0, go to IDLE.
  - Else if !coefLast && loadCount==EXP-1 (missing last / overrun): loadError pulses next cycle, loadCount <= 0, go to IDLE.
  - Else: loadCount++, state=LOAD.
- States:
  - IDLE: waits for the first beat.
  - LOAD: mid-frame, loadCount in 1..EXP-1.
  - SWAP: exactly one cycle, coefReady=0. On the exiting edge, coefs <= shadow (all taps in the same edge), bankSwapped pulses high for the following cycle, state=IDLE.
- Latency: coefs reflect the new frame 2 edges after the final beat is accepted. bankSwapped is high in that same cycle.
- Discarded frames:
  - The active bank is untouched on error.
  - Shadow contents after an error are don't-care; the next frame overwrites from index 0.
- Output flags:
  - busy = (state != IDLE).
  - bankSwapped and loadError are registered, never both high, never high longer than 1 cycle.
- rst mid-frame or during SWAP: immediate return to reset values. The active bank is zeroed, no pulse is issued, and the in-flight frame is lost.
- coefValid low mid-frame: a stall, with no timeout. The state and loadCount hold.
- NUM_REGS==1: a single beat with coefLast goes IDLE->SWAP directly.
- No arithmetic: values are stored bit-exact, with no saturation or rounding.

Optional Feature:
- Macro: COEF_SYMMETRIC_EN.
- Defined (linear-phase load):
  - EXP = (NUM_REGS+1)/2.
  - Beat i is written to shadow[i] and shadow[NUM_REGS-1-i]. For odd NUM_REGS the centre tap is written once.
  - Length checks use this EXP.
- Not defined: EXP = NUM_REGS, one beat per tap, and no mirroring logic is synthesised.

Test Plan:
- Basic load (NUM_REGS=8): after reset, stream 1..8, coefLast on 8, coefValid held high -> coefReady low exactly one cycle after beat 8; coefs={1,2,...,8} and bankSwapped=1 two edges after beat 8; busy back to 0.
- Short frame: 0x0100 x5 with coefLast on beat 5, after a prior good load of 1..8 -> loadError pulses once, coefs stay {1..8}, no bankSwapped, next frame 8x0x0040 loads cleanly.
- Overrun: 8 beats of 0x7FFF with no coefLast -> loadError on beat 8, coefs unchanged, loadCount=0; a following beat starts a new frame at index 0.
- Backpressure/stall: 8 beats with coefValid toggling 1,0,1,0 and values -32768..-32761 -> all captured in order, final coefs match, loadCount holds during gaps.
- Reset mid-frame: rst asserted after beat 4 of a frame, following a good load of 1..8 -> next cycle coefs all 0, loadCount=0, busy=0, no pulses; new frame of 8 loads normally.
- COEF_SYMMETRIC_EN, NUM_REGS=7: beats 10,20,30,40 with coefLast on 40 -> coefs={10,20,30,40,30,20,10}; a 5-beat frame raises loadError.
